csr_access_ctrl: RTL
====================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all logic is on the rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port req_valid_i, input, 1, pipeline CSR instruction valid.
REQ-004 SHALL have port req_ready_o, output, 1, block can accept a request.
REQ-005 SHALL have port req_funct3_i, input, 3, CSR instruction funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
REQ-006 SHALL have port req_addr_i, input, 12, CSR address.
REQ-007 SHALL have port req_rs1_field_i, input, 5, rs1 index, or zimm for the immediate forms.
REQ-008 SHALL have port req_rs1_data_i, input, 32, rs1 register value.
REQ-009 SHALL have port req_rd_i, input, 5, destination register index.
REQ-010 SHALL have port resp_valid_o, output, 1, response valid.
REQ-011 SHALL have port resp_ready_i, input, 1, pipeline accepts the response.
REQ-012 SHALL have port resp_rdata_o, output, 32, old CSR value for rd.
REQ-013 SHALL have port resp_rd_o, output, 5, captured req_rd_i.
REQ-014 SHALL have port resp_illegal_o, output, 1, illegal CSR access flag.
REQ-015 SHALL have port csr_addr_o, output, 12, address to the CSR unit.
REQ-016 SHALL have port csr_data_o, output, 32, write value to the CSR unit.
REQ-017 SHALL have port csr_op_o, output, 2, CSR unit op; this block always drives 00 (plain write).
REQ-018 SHALL have port csr_we_o, output, 1, CSR write enable.
REQ-019 SHALL have port csr_data_i, input, 32, combinational read data from the CSR unit.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE and RESP.
REQ-021 IDLE SHALL assert req_ready_o=1 and move to READ on req_valid_i&&req_ready_o, latching funct3, addr, rs1_field, rd and the source operand.
REQ-022 The source operand SHALL be req_rs1_data_i when funct3[2]=0, else the zero-extended req_rs1_field_i.
REQ-023 READ SHALL drive csr_addr_o=latched addr and csr_we_o=0, capture csr_data_i into rdata, then go to WRITE.
REQ-024 WRITE SHALL drive csr_data_o as follows: RW gives src; RS gives rdata|src; RC gives rdata&~src.
REQ-025 WRITE SHALL assert csr_we_o for exactly one cycle only when the write is enabled and the access is not illegal, then go to RESP.
REQ-026 The write SHALL be enabled for RW/RWI always, and for RS/RC/RSI/RCI only when rs1_field!=0.
REQ-027 funct3 000 or 100 SHALL be illegal, with no write performed.
REQ-028 RESP SHALL hold resp_valid_o=1 with resp_rdata_o, resp_rd_o and resp_illegal_o stable until resp_ready_i=1, then go to IDLE.
REQ-029 Latency SHALL be fixed: resp_valid_o rises exactly 3 cycles after the accept edge.
REQ-030 req_ready_o SHALL be 0 in READ, WRITE and RESP, so there is no back-to-back accept in the cycle resp is consumed.
REQ-031 When not in READ/WRITE, csr_addr_o SHALL be 0, csr_data_o=0, csr_we_o=0.

Reset
REQ-032 On rst_i=1 at a clock edge, state SHALL be IDLE; resp_valid_o=0, resp_rdata_o=0, resp_rd_o=0, resp_illegal_o=0, csr_we_o=0, csr_addr_o=0, csr_data_o=0, csr_op_o=00.
REQ-033 Reset mid-operation (READ/WRITE/RESP) SHALL drop the request with no CSR write issued after the reset edge.
REQ-034 req_ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-035 Macro CSR_RO_CHECK_EN SHALL control read-only checking.
REQ-036 With CSR_RO_CHECK_EN defined, an enabled write to an address with addr[11:10]==2'b11 SHALL set resp_illegal_o=1 and suppress csr_we_o, while rdata is still returned.
REQ-037 Without CSR_RO_CHECK_EN, no address check SHALL be made; illegality SHALL come from funct3 only.

Verification
REQ-038 CSRRS addr 0xC00, rs1_field=0, with the cycle count read at 0x0000_0010 -> csr_we_o never asserts, resp_rdata_o=0x10, illegal=0, resp_valid_o 3 cycles after accept.
REQ-039 CSRRW addr 0x340, src 0xDEAD_BEEF, old value 0x1 -> one-cycle csr_we_o with csr_data_o=0xDEAD_BEEF; resp_rdata_o=0x1.
REQ-040 CSRRCI addr 0x300, zimm=0x5, old value 0xF -> csr_data_o=0xA, we=1; CSRRSI with zimm=0x10 and old value 0x1 -> csr_data_o=0x11.
REQ-041 CSRRW to 0xC80 -> with CSR_RO_CHECK_EN: illegal=1, no we; without it: we=1, illegal=0.
REQ-042 funct3=100 -> illegal=1, no we; resp_ready_i held 0 for 5 cycles -> response stable and req_ready_o=0 throughout.
REQ-043 rst_i pulsed in the WRITE cycle -> no csr_we_o, all outputs at their reset values, req_ready_o=1 on the next cycle.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences one RISC-V Zicsr instruction as a read of the CSR
// unit, an optional read-modify-write, and a held response to the pipeline.
// Optional feature: define CSR_RO_CHECK_EN to flag enabled writes to the
// read-only CSR space (addr[11:10] == 2'b11) as illegal and suppress them.
module csr_access_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  req_funct3_i,
   input  logic [11:0] req_addr_i,
   input  logic [4:0]  req_rs1_field_i,
   input  logic [31:0] req_rs1_data_i,
   input  logic [4:0]  req_rd_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic [4:0]  resp_rd_o,
   output logic        resp_illegal_o,
   output logic [11:0] csr_addr_o,
   output logic [31:0] csr_data_o,
   output logic [1:0]  csr_op_o,
   output logic        csr_we_o,
   input  logic [31:0] csr_data_i
);

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t state_q, state_d;

   // Latched instruction fields; only funct3[1:0] is kept because the
   // immediate/register choice is already folded into src_q at accept time.
   logic        [1:0]        op_q;
   logic        [11:0]       addr_q;
   logic        [4:0]        rs1_field_q;
   logic        [4:0]        rd_q;
   logic signed [DATA_W-1:0] src_q;
   logic signed [DATA_W-1:0] rdata_q;

   logic accept;
   logic wr_en;
   logic ro_hit;
   logic illegal;

   // New CSR value for the read-modify-write forms; illegal encodings yield 0.
   function automatic logic signed [DATA_W-1:0] write_value(
      input logic        [1:0]        op,
      input logic signed [DATA_W-1:0] old_val,
      input logic signed [DATA_W-1:0] src
   );
      case (op)
         2'b01:   write_value = src;
         2'b10:   write_value = old_val | src;
         2'b11:   write_value = old_val & ~src;
         default: write_value = '0;
      endcase
   endfunction

   assign accept   = (state_q == IDLE) && req_valid_i;
   assign csr_op_o = 2'b00;

   // Set/clear forms with rs1 = x0 (or zimm = 0) are pure reads.
   assign wr_en = (op_q == 2'b01) || (rs1_field_q != 5'd0);

`ifdef CSR_RO_CHECK_EN
   assign ro_hit = wr_en && (addr_q[11:10] == 2'b11);
`else
   assign ro_hit = 1'b0;
`endif

   assign illegal = (op_q == 2'b00) || ro_hit;

   // State register; reset drops any in-flight request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture at accept and old-value capture during READ.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q        <= req_funct3_i[1:0];
         addr_q      <= req_addr_i;
         rs1_field_q <= req_rs1_field_i;
         rd_q        <= req_rd_i;
         src_q       <= req_funct3_i[2] ? DATA_W'(req_rs1_field_i) : req_rs1_data_i;
      end
      if (state_q == READ) begin
         rdata_q <= csr_data_i;
      end
   end

   // Next-state and output decode; every output idles at zero outside its state.
   always_comb begin
      state_d        = state_q;
      req_ready_o    = 1'b0;
      resp_valid_o   = 1'b0;
      resp_rdata_o   = '0;
      resp_rd_o      = '0;
      resp_illegal_o = 1'b0;
      csr_addr_o     = '0;
      csr_data_o     = '0;
      csr_we_o       = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               state_d = READ;
            end
         end
         READ: begin
            csr_addr_o = addr_q;
            state_d    = WRITE;
         end
         WRITE: begin
            csr_addr_o = addr_q;
            csr_data_o = write_value(op_q, rdata_q, src_q);
            // A reset arriving in this cycle cancels the commit.
            csr_we_o   = wr_en && !illegal && !rst_i;
            state_d    = RESP;
         end
         RESP: begin
            resp_valid_o   = 1'b1;
            resp_rdata_o   = rdata_q;
            resp_rd_o      = rd_q;
            resp_illegal_o = illegal;
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
